// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/IR/MAR datapath slice: opcode constants and flag bundle.
package alu_pkg;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_EOR   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_RSB   = 5'b00011;
    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_ADC   = 5'b00101;
    localparam logic [4:0] OP_SBC   = 5'b00110;
    localparam logic [4:0] OP_RSC   = 5'b00111;
    localparam logic [4:0] OP_TST   = 5'b01000;
    localparam logic [4:0] OP_TEQ   = 5'b01001;
    localparam logic [4:0] OP_CMP   = 5'b01010;
    localparam logic [4:0] OP_CMN   = 5'b01011;
    localparam logic [4:0] OP_ORR   = 5'b01100;
    localparam logic [4:0] OP_MOV   = 5'b01101;
    localparam logic [4:0] OP_BIC   = 5'b01110;
    localparam logic [4:0] OP_MVN   = 5'b01111;
    localparam logic [4:0] OP_INC4  = 5'b10000;
    localparam logic [4:0] OP_PASSA = 5'b10001;
    localparam logic [4:0] OP_PASSB = 5'b10010;
    localparam logic [4:0] OP_DEC4  = 5'b10011;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_ir_mar_if.sv
// Control/datapath bus of the ALU/IR/MAR slice; master = control side, slave = datapath.
interface alu_ir_mar_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        cin;
    logic        FRLd;
    logic        IRLd;
    logic [31:0] ir_in;
    logic        MARLd;
    logic [31:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        flag_v;
    logic [31:0] ir_out;
    logic [31:0] mar_out;

    modport master (
        output a, b, op, cin, FRLd, IRLd, ir_in, MARLd,
        input  result, flag_z, flag_n, flag_c, flag_v, ir_out, mar_out
    );

    modport slave (
        input  a, b, op, cin, FRLd, IRLd, ir_in, MARLd,
        output result, flag_z, flag_n, flag_c, flag_v, ir_out, mar_out
    );
endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit ALU with Z/N/C/V flags; all arithmetic goes through one x + y + ci adder.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    input  logic        c,
    output logic [31:0] result,
    output flags_t      flags
);

    logic [31:0] x;
    logic [31:0] y;
    logic        ci;
    logic        arith;
    logic [32:0] sum;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        x      = '0;
        y      = '0;
        ci     = 1'b0;
        arith  = 1'b0;
        result = '0;
        unique case (op)
            OP_AND, OP_TST:  result = a & b;
            OP_EOR, OP_TEQ:  result = a ^ b;
            OP_ORR:          result = a | b;
            OP_MOV, OP_PASSB: result = b;
            OP_BIC:          result = a & ~b;
            OP_MVN:          result = ~b;
            OP_PASSA:        result = a;
            // Subtraction is A + ~B + carry-in, so C=1 means no borrow.
            OP_SUB, OP_CMP:  begin x = a; y = ~b; ci = 1'b1; arith = 1'b1; end
            OP_RSB:          begin x = b; y = ~a; ci = 1'b1; arith = 1'b1; end
            OP_ADD, OP_CMN:  begin x = a; y = b;  ci = 1'b0; arith = 1'b1; end
            OP_ADC:          begin x = a; y = b;  ci = c;    arith = 1'b1; end
            OP_SBC:          begin x = a; y = ~b; ci = c;    arith = 1'b1; end
            OP_RSC:          begin x = b; y = ~a; ci = c;    arith = 1'b1; end
            OP_INC4:         begin x = a; y = 32'd4;  ci = 1'b0; arith = 1'b1; end
            OP_DEC4:         begin x = a; y = ~32'd4; ci = 1'b1; arith = 1'b1; end
            default:         result = '0;
        endcase

        sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        if (arith) begin
            result = sum[31:0];
        end

        flags.z = (result == 32'd0);
        flags.n = result[31];
        flags.c = arith ? sum[32] : c;
        flags.v = arith & (x[31] == y[31]) & (sum[31] != x[31]);
    end

endmodule

// File: rtl/alu_ir_mar.sv
// ALU + Instruction Register + Memory Address Register datapath slice.
// Optional macro FLAG_REG_EN adds a registered Z/N/C/V flag set loaded by FRLd.
module alu_ir_mar
    import alu_pkg::*;
(
    input logic          CLK,
    input logic          CLR,
    alu_ir_mar_if.slave  bus
);

    logic [31:0] alu_result;
    flags_t      alu_flags;
    flags_t      flags_shown;
    logic        c_used;
    logic [31:0] ir_q;
    logic [31:0] mar_q;

    alu_core u_alu_core (
        .a      (bus.a),
        .b      (bus.b),
        .op     (bus.op),
        .c      (c_used),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // NOTE: sequential state uses non-blocking assignments; CLR is tested first so it beats any load.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ir_q  <= '0;
            mar_q <= '0;
        end else begin
            if (bus.IRLd)  ir_q  <= bus.ir_in;
            if (bus.MARLd) mar_q <= alu_result;
        end
    end

`ifdef FLAG_REG_EN
    flags_t flag_q;
    logic   unused_cin;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            flag_q <= '0;
        end else if (bus.FRLd) begin
            flag_q <= alu_flags;
        end
    end

    assign c_used      = flag_q.c;
    assign flags_shown = flag_q;
    assign unused_cin  = bus.cin;
`else
    logic unused_frld;

    assign c_used      = bus.cin;
    assign flags_shown = alu_flags;
    assign unused_frld = bus.FRLd;
`endif

    assign bus.result  = alu_result;
    assign bus.flag_z  = flags_shown.z;
    assign bus.flag_n  = flags_shown.n;
    assign bus.flag_c  = flags_shown.c;
    assign bus.flag_v  = flags_shown.v;
    assign bus.ir_out  = ir_q;
    assign bus.mar_out = mar_q;

endmodule

// File: tb/tb_alu_ir_mar.sv
// Self-checking bench for alu_ir_mar: directed table, randomized run against an arithmetic model,
// and hand-written IR/MAR/reset (and FLAG_REG_EN flag register) sequences.
module tb_alu_ir_mar;
    import alu_pkg::*;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_fail;

    alu_ir_mar_if bus ();

    alu_ir_mar dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;   // {z,n,c,v}
    } vec_t;

    vec_t        vecs[18];
    logic [3:0]  mf;          // model of the flag register
    logic [31:0] ir_exp;
    logic [31:0] mar_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic, C/V read off the true unsigned/signed results.
    function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic c, output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, cc, ures, sres;
        int     kind;   // 0 logical, 1 addition, 2 subtraction
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cc = c ? 64'sd1 : 64'sd0;
        kind = 0; r = '0; ures = 0; sres = 0;
        case (op)
            5'd0, 5'd8: r = a & b;
            5'd1, 5'd9: r = a ^ b;
            5'd12:      r = a | b;
            5'd13, 5'd18: r = b;
            5'd14:      r = a & ~b;
            5'd15:      r = ~b;
            5'd17:      r = a;
            5'd2, 5'd10: begin kind = 2; ures = ua - ub; sres = sa - sb; end
            5'd3:       begin kind = 2; ures = ub - ua; sres = sb - sa; end
            5'd4, 5'd11: begin kind = 1; ures = ua + ub; sres = sa + sb; end
            5'd5:       begin kind = 1; ures = ua + ub + cc; sres = sa + sb + cc; end
            5'd6:       begin kind = 2; ures = ua - ub - (1 - cc); sres = sa - sb - (1 - cc); end
            5'd7:       begin kind = 2; ures = ub - ua - (1 - cc); sres = sb - sa - (1 - cc); end
            5'd16:      begin kind = 1; ures = ua + 4; sres = sa + 4; end
            5'd19:      begin kind = 2; ures = ua - 4; sres = sa - 4; end
            default:    r = '0;
        endcase
        if (kind != 0) r = ures[31:0];
        f[3] = (r == 32'd0);
        f[2] = r[31];
        if (kind == 0)      f[1] = c;
        else if (kind == 1) f[1] = (ures >= 64'sh1_0000_0000);
        else                f[1] = (ures >= 64'sd0);
        f[0] = (kind != 0) && ((sres > 64'sd2147483647) || (sres < -64'sd2147483648));
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

`ifdef FLAG_REG_EN
    // Force the registered C to a known value via ADD 0xFFFFFFFF + c.
    task automatic preload_c(input logic c);
        logic [31:0] r;
        logic [3:0]  f;
        bus.op = OP_ADD; bus.a = 32'hFFFF_FFFF; bus.b = {31'd0, c}; bus.FRLd = 1'b1;
        ref_alu(OP_ADD, bus.a, bus.b, mf[1], r, f);
        tick();
        mf = f;
        bus.FRLd = 1'b0;
    endtask
`endif

    task automatic apply_vec(input vec_t v);
`ifdef FLAG_REG_EN
        preload_c(v.cin);
`endif
        bus.op = v.op; bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.FRLd = 1'b1;
        #1;
        check({v.name, "_result"}, bus.result, v.exp_r);
`ifdef FLAG_REG_EN
        tick();
        mf = v.exp_f;
`endif
        check({v.name, "_flags"}, {28'd0, flags_now()}, {28'd0, v.exp_f});
        bus.FRLd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic        c_model;

        n_cmp = 0; n_fail = 0;
        mf = '0; ir_exp = '0; mar_exp = '0;

        vecs[0]  = '{"add_ovf",   OP_ADD,   32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 4'b0101};
        vecs[1]  = '{"sub_eq",    OP_SUB,   32'd5,         32'd5,         1'b0, 32'h0000_0000, 4'b1010};
        vecs[2]  = '{"rsb_borrow",OP_RSB,   32'd1,         32'd0,         1'b0, 32'hFFFF_FFFF, 4'b0100};
        vecs[3]  = '{"adc_wrap",  OP_ADC,   32'hFFFF_FFFF, 32'd0,         1'b1, 32'h0000_0000, 4'b1010};
        vecs[4]  = '{"bic_c1",    OP_BIC,   32'h0000_00FF, 32'h0000_000F, 1'b1, 32'h0000_00F0, 4'b0010};
        vecs[5]  = '{"bic_c0",    OP_BIC,   32'h0000_00FF, 32'h0000_000F, 1'b0, 32'h0000_00F0, 4'b0000};
        vecs[6]  = '{"inc4",      OP_INC4,  32'h0000_0010, 32'd0,         1'b0, 32'h0000_0014, 4'b0000};
        vecs[7]  = '{"dec4_neg",  OP_DEC4,  32'd2,         32'd0,         1'b0, 32'hFFFF_FFFE, 4'b0100};
        vecs[8]  = '{"dec4_ovf",  OP_DEC4,  32'h8000_0000, 32'd0,         1'b0, 32'h7FFF_FFFC, 4'b0011};
        vecs[9]  = '{"undef_c1",  5'b10100, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0000_0000, 4'b1010};
        vecs[10] = '{"undef_c0",  5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b1000};
        vecs[11] = '{"mvn",       OP_MVN,   32'd7,         32'd0,         1'b1, 32'hFFFF_FFFF, 4'b0110};
        vecs[12] = '{"sbc_c0",    OP_SBC,   32'd5,         32'd3,         1'b0, 32'h0000_0001, 4'b0010};
        vecs[13] = '{"rsc_c0",    OP_RSC,   32'd3,         32'd5,         1'b0, 32'h0000_0001, 4'b0010};
        vecs[14] = '{"sbc_borrow",OP_SBC,   32'd0,         32'd0,         1'b0, 32'hFFFF_FFFF, 4'b0100};
        vecs[15] = '{"cmn_ovf",   OP_CMN,   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1011};
        vecs[16] = '{"passa",     OP_PASSA, 32'hDEAD_BEEF, 32'd0,         1'b0, 32'hDEAD_BEEF, 4'b0100};
        vecs[17] = '{"teq_eq",    OP_TEQ,   32'hAAAA_5555, 32'hAAAA_5555, 1'b1, 32'h0000_0000, 4'b1010};

        bus.a = '0; bus.b = '0; bus.op = OP_AND; bus.cin = 1'b0;
        bus.FRLd = 1'b0; bus.IRLd = 1'b0; bus.MARLd = 1'b0; bus.ir_in = '0;
        clr = 1'b1;
        tick();
        check("reset_ir", bus.ir_out, 32'd0);
        check("reset_mar", bus.mar_out, 32'd0);
`ifdef FLAG_REG_EN
        check("reset_flags", {28'd0, flags_now()}, 32'd0);
`endif
        clr = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Randomized run: every cycle may load IR/MAR/flags, occasionally with CLR.
        for (int i = 0; i < 400; i++) begin
            bus.op    = 5'($urandom_range(0, 31));
            bus.a     = rnd32();
            bus.b     = rnd32();
            bus.cin   = 1'($urandom_range(0, 1));
            bus.IRLd  = 1'($urandom_range(0, 1));
            bus.MARLd = 1'($urandom_range(0, 1));
            bus.FRLd  = 1'($urandom_range(0, 1));
            bus.ir_in = $urandom;
            clr       = ($urandom_range(0, 15) == 0);
`ifdef FLAG_REG_EN
            c_model = mf[1];
`else
            c_model = bus.cin;
`endif
            ref_alu(bus.op, bus.a, bus.b, c_model, r, f);
            #1;
            check($sformatf("rnd%0d_result", i), bus.result, r);
`ifndef FLAG_REG_EN
            check($sformatf("rnd%0d_flags", i), {28'd0, flags_now()}, {28'd0, f});
`endif
            tick();
            if (clr) begin
                ir_exp = '0; mar_exp = '0; mf = '0;
            end else begin
                if (bus.IRLd)  ir_exp  = bus.ir_in;
                if (bus.MARLd) mar_exp = r;
                if (bus.FRLd)  mf      = f;
            end
            check($sformatf("rnd%0d_ir", i), bus.ir_out, ir_exp);
            check($sformatf("rnd%0d_mar", i), bus.mar_out, mar_exp);
`ifdef FLAG_REG_EN
            check($sformatf("rnd%0d_flagreg", i), {28'd0, flags_now()}, {28'd0, mf});
`endif
        end
        clr = 1'b0; bus.IRLd = 1'b0; bus.MARLd = 1'b0; bus.FRLd = 1'b0;

        // IR load then hold
        bus.IRLd = 1'b1; bus.ir_in = 32'hE281_1001;
        tick();
        check("ir_load", bus.ir_out, 32'hE281_1001);
        bus.IRLd = 1'b0; bus.ir_in = 32'h1234_5678;
        tick();
        check("ir_hold", bus.ir_out, 32'hE281_1001);

        // MAR load from A+4, then hold
        bus.op = OP_INC4; bus.a = 32'h10; bus.MARLd = 1'b1;
        tick();
        check("mar_load", bus.mar_out, 32'h14);
        bus.MARLd = 1'b0; bus.a = 32'h100;
        tick();
        check("mar_hold", bus.mar_out, 32'h14);

        // Both registers on the same edge
        bus.IRLd = 1'b1; bus.ir_in = 32'hCAFE_F00D;
        bus.op = OP_PASSB; bus.b = 32'h8765_4321; bus.MARLd = 1'b1;
        tick();
        check("both_ir", bus.ir_out, 32'hCAFE_F00D);
        check("both_mar", bus.mar_out, 32'h8765_4321);

        // CLR wins over simultaneous loads
        clr = 1'b1; bus.ir_in = 32'hFFFF_FFFF; bus.op = OP_PASSA; bus.a = 32'hFFFF_FFFF;
        tick();
        check("clr_ir", bus.ir_out, 32'd0);
        check("clr_mar", bus.mar_out, 32'd0);
        clr = 1'b0; bus.IRLd = 1'b0; bus.MARLd = 1'b0;

`ifdef FLAG_REG_EN
        bus.op = OP_CMP; bus.a = 32'd3; bus.b = 32'd3; bus.FRLd = 1'b1;
        tick();
        check("flagreg_cmp", {28'd0, flags_now()}, {28'd0, 4'b1010});
        bus.FRLd = 1'b0; bus.op = OP_AND; bus.a = 32'd1; bus.b = 32'd2; bus.cin = 1'b0;
        tick();
        check("flagreg_hold", {28'd0, flags_now()}, {28'd0, 4'b1010});
        bus.FRLd = 1'b1; clr = 1'b1;
        tick();
        check("flagreg_clr", {28'd0, flags_now()}, 32'd0);
        clr = 1'b0; bus.FRLd = 1'b0;
`else
        bus.op = OP_CMP; bus.a = 32'd3; bus.b = 32'd3; bus.FRLd = 1'b1;
        tick();
        bus.FRLd = 1'b0; bus.op = OP_AND; bus.a = 32'd1; bus.b = 32'd2; bus.cin = 1'b0;
        #1;
        check("comb_flags_ignore_frld", {28'd0, flags_now()}, {28'd0, 4'b1000});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
